gpu_op_arbiter: RTL and testbench

- Shares the single GPU op FIFO write port between two op producers: req0 = game cpu, req1 = HUD/score overlay generator.
- Sits between the producers and the gpu op FIFO write side, which supplies `op_full`.
- Ops are grouped into packets. A packet is one or more ops, the final op flagged `last`.
- A granted producer keeps the port until its `last` op transfers, so draw sequences are never interleaved.
- Between packets, grants alternate round-robin.
- A lock watchdog releases a producer that stalls mid-packet.

---
 rtl/gpu_op_arbiter.sv | 128 ++++++++++++
 tb/tb_gpu_op_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_op_arbiter.sv
// rtl/gpu_op_arbiter.sv - two-producer packet-locked round-robin arbiter for the GPU op FIFO write port
// Optional: define GPU_OP_ARBITER_STATS_EN to add stat_ops0/stat_ops1/stat_timeouts counters.
module gpu_op_arbiter #(
  parameter int OP_WIDTH = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic                req0_last,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic                req1_last,
  input  logic                req1_valid,
  output logic                req1_ready,
  output logic [OP_WIDTH-1:0] op,
  output logic                op_wr_en,
  input  logic                op_full,
  output logic                busy,
`ifdef GPU_OP_ARBITER_STATS_EN
  output logic [15:0]         stat_ops0,
  output logic [15:0]         stat_ops1,
  output logic [7:0]          stat_timeouts,
`endif
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  // Counter is sized to hold TIMEOUT; a minimum width of 1 bit keeps declarations legal when the watchdog is off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLIM = TLIM_I[CW-1:0];

  state_t        state, state_nxt;
  logic          rr_ptr, rr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic          grant0, grant1, xfer0, xfer1, xfer_last, stall;

  // Grant selection and the zero-latency transfer path; outputs are forced quiet while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | ~rr_ptr);
        grant1 = req1_valid & (~req0_valid | rr_ptr);
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: ;
    endcase
    xfer0      = rst & ce & grant0 & req0_valid & ~op_full;
    xfer1      = rst & ce & grant1 & req1_valid & ~op_full;
    req0_ready = xfer0;
    req1_ready = xfer1;
    op_wr_en   = xfer0 | xfer1;
    busy       = rst & (state != IDLE);
    if (!rst)        op = '0;
    else if (grant0) op = req0_op;
    else if (grant1) op = req1_op;
    else             op = '0;
  end

  // Next-state: packet lock/release, round-robin pointer and lock watchdog; a transfer beats a stall.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    stall     = ((state == LOCK0) & ~req0_valid) | ((state == LOCK1) & ~req1_valid);
    xfer_last = (xfer0 & req0_last) | (xfer1 & req1_last);
    if (ce) begin
      if (xfer0 | xfer1) begin
        cnt_nxt = '0;
        if (xfer_last) begin
          state_nxt = IDLE;
          rr_nxt    = xfer0;
        end else begin
          state_nxt = xfer0 ? LOCK0 : LOCK1;
        end
      end else if (stall && (TIMEOUT > 0)) begin
        if (cnt == TLIM) begin
          state_nxt = IDLE;
          rr_nxt    = (state == LOCK0);
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  // State register; timeout_err is a one-cycle registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

`ifdef GPU_OP_ARBITER_STATS_EN
  // Debug counters; they wrap naturally and only move on ce cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops0     <= '0;
      stat_ops1     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (xfer0)   stat_ops0     <= stat_ops0 + 16'd1;
      if (xfer1)   stat_ops1     <= stat_ops1 + 16'd1;
      if (err_nxt) stat_timeouts <= stat_timeouts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// tb/tb_gpu_op_arbiter.sv - vector table plus randomized reference-model bench for gpu_op_arbiter
module tb_gpu_op_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, ce, op_full;
  logic [31:0] req0_op, req1_op, op;
  logic        req0_last, req0_valid, req0_ready;
  logic        req1_last, req1_valid, req1_ready;
  logic        op_wr_en, busy, timeout_err;
`ifdef GPU_OP_ARBITER_STATS_EN
  logic [15:0] stat_ops0, stat_ops1;
  logic [7:0]  stat_timeouts;
`endif

  always #5 clk = ~clk;

  gpu_op_arbiter #(.OP_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req0_op(req0_op), .req0_last(req0_last), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_op(req1_op), .req1_last(req1_last), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .op(op), .op_wr_en(op_wr_en), .op_full(op_full), .busy(busy),
`ifdef GPU_OP_ARBITER_STATS_EN
    .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_timeouts(stat_timeouts),
`endif
    .timeout_err(timeout_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, whose turn it is, how long the owner has stalled.
  int m_owner = -1;
  int m_rr = 0;
  int m_cnt = 0;
  bit m_err = 0;
  int m_ops0 = 0, m_ops1 = 0, m_tos = 0;
  int m_g;
  bit m_x;

  function automatic void model_eval();
    m_g = -1;
    if (rst) begin
      if (m_owner >= 0) m_g = m_owner;
      else if (req0_valid && req1_valid) m_g = m_rr;
      else if (req0_valid) m_g = 0;
      else if (req1_valid) m_g = 1;
    end
    m_x = rst && ce && (m_g >= 0) && !op_full && ((m_g == 0) ? req0_valid : req1_valid);
  endfunction

  function automatic void model_step();
    bit nerr;
    bit lst;
    model_eval();
    if (!rst) begin
      m_owner = -1; m_rr = 0; m_cnt = 0; m_err = 0;
      m_ops0 = 0; m_ops1 = 0; m_tos = 0;
      return;
    end
    nerr = 0;
    if (ce) begin
      if (m_x) begin
        m_cnt = 0;
        if (m_g == 0) m_ops0++; else m_ops1++;
        lst = (m_g == 0) ? req0_last : req1_last;
        if (lst) begin m_owner = -1; m_rr = 1 - m_g; end
        else m_owner = m_g;
      end else if (m_owner >= 0 && !((m_owner == 0) ? req0_valid : req1_valid)) begin
        m_cnt++;
        if (m_cnt == TO) begin
          nerr = 1; m_rr = 1 - m_owner; m_owner = -1; m_cnt = 0; m_tos++;
        end
      end
    end
    m_err = nerr;
  endfunction

  task automatic chk_model(input string tag);
    logic [31:0] e_op;
    model_eval();
    e_op = (m_g == 0) ? req0_op : (m_g == 1) ? req1_op : 32'h0;
    chk({tag, " ready0"}, 32'(req0_ready), 32'(m_x && m_g == 0));
    chk({tag, " ready1"}, 32'(req1_ready), 32'(m_x && m_g == 1));
    chk({tag, " op_wr_en"}, 32'(op_wr_en), 32'(m_x));
    chk({tag, " op"}, op, e_op);
    chk({tag, " busy"}, 32'(busy), 32'(rst && m_owner >= 0));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(m_err));
`ifdef GPU_OP_ARBITER_STATS_EN
    chk({tag, " stat_ops0"}, 32'(stat_ops0), m_ops0 & 32'hFFFF);
    chk({tag, " stat_ops1"}, 32'(stat_ops1), m_ops1 & 32'hFFFF);
    chk({tag, " stat_timeouts"}, 32'(stat_timeouts), m_tos & 32'hFF);
`endif
  endtask

  typedef struct {
    bit rst, ce, v0, l0;
    logic [31:0] o0;
    bit v1, l1;
    logic [31:0] o1;
    bit full;
    bit r0, r1, wr;
    logic [31:0] eop;
    bit bsy, terr;
  } vec_t;

  function automatic vec_t mk(bit rs, bit c, bit v0, bit l0, logic [31:0] o0, bit v1, bit l1,
                              logic [31:0] o1, bit f, bit r0, bit r1, bit wr, logic [31:0] eop,
                              bit bsy, bit terr);
    vec_t v;
    v.rst = rs; v.ce = c; v.v0 = v0; v.l0 = l0; v.o0 = o0; v.v1 = v1; v.l1 = l1; v.o1 = o1;
    v.full = f; v.r0 = r0; v.r1 = r1; v.wr = wr; v.eop = eop; v.bsy = bsy; v.terr = terr;
    return v;
  endfunction

  task automatic drive(bit rs, bit c, bit v0, bit l0, logic [31:0] o0, bit v1, bit l1,
                       logic [31:0] o1, bit f);
    rst = rs; ce = c; req0_valid = v0; req0_last = l0; req0_op = o0;
    req1_valid = v1; req1_last = l1; req1_op = o1; op_full = f;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // reset with both valid
    vecs.push_back(mk(0,1, 1,1,32'h11, 1,1,32'h22, 0,  0,0,0,32'h0,  0,0));
    // single requester, same-cycle transfer
    vecs.push_back(mk(1,1, 1,1,32'h11, 0,1,32'h22, 0,  1,0,1,32'h11, 0,0));
    vecs.push_back(mk(1,1, 0,1,32'h11, 1,1,32'h22, 0,  0,1,1,32'h22, 0,0));
    // round-robin alternation
    for (int k = 0; k < 2; k++) begin
      vecs.push_back(mk(1,1, 1,1,32'hA0, 1,1,32'hB0, 0,  1,0,1,32'hA0, 0,0));
      vecs.push_back(mk(1,1, 1,1,32'hA0, 1,1,32'hB0, 0,  0,1,1,32'hB0, 0,0));
    end
    // packet lock: req1 waits out a 3-op packet
    vecs.push_back(mk(1,1, 1,0,32'hC1, 1,1,32'hB1, 0,  1,0,1,32'hC1, 0,0));
    vecs.push_back(mk(1,1, 1,0,32'hC2, 1,1,32'hB1, 0,  1,0,1,32'hC2, 1,0));
    vecs.push_back(mk(1,1, 1,1,32'hC3, 1,1,32'hB1, 0,  1,0,1,32'hC3, 1,0));
    vecs.push_back(mk(1,1, 1,1,32'hD0, 1,1,32'hB2, 0,  0,1,1,32'hB2, 0,0));
    // backpressure mid-packet
    vecs.push_back(mk(1,1, 1,0,32'hE1, 0,1,32'hB3, 0,  1,0,1,32'hE1, 0,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,1, 1,0,32'hE2, 1,1,32'hB3, 1,  0,0,0,32'hE2, 1,0));
    vecs.push_back(mk(1,1, 1,1,32'hE2, 1,1,32'hB3, 0,  1,0,1,32'hE2, 1,0));
    // watchdog release after TO stalled cycles
    vecs.push_back(mk(1,1, 1,0,32'hF1, 0,1,32'h33, 0,  1,0,1,32'hF1, 0,0));
    for (int k = 0; k < TO; k++)
      vecs.push_back(mk(1,1, 0,0,32'hF2, 1,1,32'h33, 0,  0,0,0,32'hF2, 1,0));
    vecs.push_back(mk(1,1, 0,0,32'hF2, 1,1,32'h33, 0,  0,1,1,32'h33, 0,1));
    vecs.push_back(mk(1,1, 0,0,32'hF2, 1,1,32'h33, 0,  0,1,1,32'h33, 0,0));
    // ce gating
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0, 1,1,32'hA0, 1,1,32'hB0, 0,  0,0,0,32'hA0, 0,0));
    vecs.push_back(mk(1,1, 1,1,32'hA0, 1,1,32'hB0, 0,  1,0,1,32'hA0, 0,0));
    // reset mid-packet returns to IDLE with rr_ptr=0
    vecs.push_back(mk(1,1, 1,0,32'h44, 0,1,32'hB0, 0,  1,0,1,32'h44, 0,0));
    vecs.push_back(mk(0,1, 1,0,32'h44, 1,1,32'hB0, 0,  0,0,0,32'h0,  0,0));
    vecs.push_back(mk(1,1, 1,1,32'h45, 1,1,32'hB0, 0,  1,0,1,32'h45, 0,0));

    drive(0,0, 0,0,32'h0, 0,0,32'h0, 0);
    tick();

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].ce, vecs[i].v0, vecs[i].l0, vecs[i].o0,
            vecs[i].v1, vecs[i].l1, vecs[i].o1, vecs[i].full);
      #4;
      chk({t, " ready0"}, 32'(req0_ready), 32'(vecs[i].r0));
      chk({t, " ready1"}, 32'(req1_ready), 32'(vecs[i].r1));
      chk({t, " op_wr_en"}, 32'(op_wr_en), 32'(vecs[i].wr));
      chk({t, " op"}, op, vecs[i].eop);
      chk({t, " busy"}, 32'(busy), 32'(vecs[i].bsy));
      chk({t, " timeout_err"}, 32'(timeout_err), 32'(vecs[i].terr));
`ifdef GPU_OP_ARBITER_STATS_EN
      chk({t, " stat_ops0"}, 32'(stat_ops0), m_ops0 & 32'hFFFF);
      chk({t, " stat_timeouts"}, 32'(stat_timeouts), m_tos & 32'hFF);
`endif
      tick();
    end

    // randomized run against the reference model
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 4, $urandom,
            $urandom_range(0, 3) == 0);
      #4;
      chk_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
